// File: rtl/exec_ctrl.sv
// Run/halt/single-step controller for the two-phase 4-bit core: gates the core
// clock-enable, holds a PC breakpoint and counts retired instructions.
module exec_ctrl #(
    parameter int ADDR_W = 12,
    parameter int STEP_W = 8,
    parameter int ICNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run_cmd,
    input  logic              halt_cmd,
    input  logic              step_cmd,
    input  logic [STEP_W-1:0] step_n,
    input  logic              bp_en,
    input  logic [ADDR_W-1:0] bp_addr,
    input  logic [ADDR_W-1:0] pc,
    input  logic              phase,
    output logic              cpu_en,
    output logic              halted,
    output logic              bp_hit,
    output logic [1:0]        state,
    output logic [ICNT_W-1:0] icount
);

    typedef enum logic [1:0] {
        S_HALT  = 2'b00,
        S_RUN   = 2'b01,
        S_STEP  = 2'b10,
        S_DRAIN = 2'b11
    } state_t;

    state_t              state_q, state_nxt;
    logic [STEP_W-1:0]   step_cnt, step_cnt_nxt;
    logic                skip_bp, skip_bp_nxt;
    logic                bp_hit_q, bp_hit_nxt;
    logic                bp_fire;
    logic                retire;

    function automatic logic [STEP_W-1:0] step_load(input logic [STEP_W-1:0] n);
        return (n == '0) ? STEP_W'(1) : n;
    endfunction

    always_comb begin
        bp_fire      = 1'b0;
        cpu_en       = 1'b0;
        retire       = 1'b0;
        state_nxt    = state_q;
        step_cnt_nxt = step_cnt;
        bp_hit_nxt   = bp_hit_q;

        // The breakpoint suppresses the fetch in the very cycle it matches.
        if ((state_q == S_RUN) || (state_q == S_STEP))
            bp_fire = bp_en && !phase && (pc == bp_addr) && !skip_bp;
        cpu_en      = (state_q != S_HALT) && !bp_fire;
        retire      = cpu_en && phase;
        skip_bp_nxt = skip_bp && !retire;

        case (state_q)
            S_HALT: begin
                if (halt_cmd) begin
                    state_nxt = S_HALT;
                end else if (step_cmd) begin
                    state_nxt    = S_STEP;
                    step_cnt_nxt = step_load(step_n);
                    bp_hit_nxt   = 1'b0;
                    skip_bp_nxt  = 1'b1;
                end else if (run_cmd) begin
                    state_nxt   = S_RUN;
                    bp_hit_nxt  = 1'b0;
                    skip_bp_nxt = 1'b1;
                end
            end
            S_RUN: begin
                if (bp_fire) begin
                    state_nxt  = S_HALT;
                    bp_hit_nxt = 1'b1;
                end else if (halt_cmd) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_STEP: begin
                if (bp_fire) begin
                    state_nxt  = S_HALT;
                    bp_hit_nxt = 1'b1;
                end else if (halt_cmd) begin
                    state_nxt = S_DRAIN;
                end else if (retire) begin
                    if (step_cnt == STEP_W'(1))
                        state_nxt = S_HALT;
                    step_cnt_nxt = step_cnt - STEP_W'(1);
                end
            end
            S_DRAIN: begin
                if (retire)
                    state_nxt = S_HALT;
            end
            default: state_nxt = S_HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_HALT;
            halted   <= 1'b1;
            bp_hit_q <= 1'b0;
            skip_bp  <= 1'b0;
            step_cnt <= '0;
            icount   <= '0;
        end else begin
            state_q  <= state_nxt;
            halted   <= (state_nxt == S_HALT);
            bp_hit_q <= bp_hit_nxt;
            skip_bp  <= skip_bp_nxt;
            step_cnt <= step_cnt_nxt;
            if (retire)
                icount <= icount + ICNT_W'(1);
        end
    end

    assign state  = state_q;
    assign bp_hit = bp_hit_q;

endmodule
